fifo_stream: RTL and testbench
==============================

Name: fifo_stream

Overview:
- Next-generation single-clock synchronous FIFO that replaces the fixed-mode FIFO in new designs.
- Depth, width, read mode (normal / showahead) and almost-thresholds are all parametrised.
- Adds write-through-when-full, a synchronous flush, sticky overflow/underflow error flags and a registered almost-flag output.
- Sits between stream producers and consumers inside one clock domain; the storage array is inferred inside the block.

Parameters:
- DWIDTH, 16: data word width in bits.
- AWIDTH, 4: address width; depth = 2**AWIDTH words.
- SHOWAHEAD, 1: 1 = head word presented on q_o without a request; 0 = q_o updates one cycle after an accepted read.
- ALMOST_FULL_VALUE, 12: almost_full_o asserts when usedw >= this value (1..2**AWIDTH).
- ALMOST_EMPTY_VALUE, 2: almost_empty_o asserts when usedw < this value (1..2**AWIDTH).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- arst_n_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous clear of contents and error flags.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  FIFO holds 0 words.
- full_o  out  1  FIFO holds 2**AWIDTH words.
- usedw_o  out  AWIDTH+1  current word count, 0..2**AWIDTH.
- almost_full_o  out  1  registered, usedw >= ALMOST_FULL_VALUE.
- almost_empty_o  out  1  registered, usedw < ALMOST_EMPTY_VALUE.
- overflow_o  out  1  sticky: a write was dropped.
- underflow_o  out  1  sticky: a read was ignored.

Behaviour:
- Reset (arst_n_i=0, asynchronous): pointers=0, usedw_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0, q_o=0. Storage contents are not reset.
- Read acceptance: rd_ok = rdreq_i & ~empty_o.
- Write acceptance: wr_ok = wrreq_i & (~full_o | rd_ok). A write while full is accepted only if a read is accepted in the same cycle.
- Pointers and count:
  - Read and write pointers are AWIDTH wide and wrap naturally from 2**AWIDTH-1 to 0.
  - usedw increments on wr_ok & ~rd_ok, decrements on rd_ok & ~wr_ok, and is otherwise unchanged.
  - empty_o and full_o are decoded from the registered usedw.
- Error flags:
  - overflow_o sets on wrreq_i & ~wr_ok.
  - underflow_o sets on rdreq_i & ~rd_ok.
  - Both hold until flush or reset. They set on the edge after the offending request.
- Almost flags: registered from the next-state count, so they are valid in the same cycle usedw_o reflects the change.
- SHOWAHEAD=0 (normal mode):
  - Read latency is 1: q_o updates on the edge after rd_ok with the word at the read pointer.
  - q_o holds its value otherwise.
- SHOWAHEAD=1 (showahead mode):
  - Whenever empty_o=0, q_o equals the oldest stored word.
  - A word written into an empty FIFO appears on q_o in the same cycle empty_o falls, i.e. one edge after the write.
  - On rd_ok the next word is on q_o after the edge, provided usedw was >= 2 before the read. The implementation uses a prefetch/bypass register so there is no bubble.
  - When empty_o=1, q_o holds its last value.
- Simultaneous read and write:
  - Empty FIFO: the read is ignored and underflow_o sets; the write is accepted.
  - Full FIFO: both are accepted; usedw stays at 2**AWIDTH; the new word is stored at the slot just freed.
- Flush (flush_i=1 at an edge):
  - Next state equals the reset state except q_o, which holds.
  - flush_i has priority over wrreq_i and rdreq_i in the same cycle; neither request is accepted and no error flag sets.
- Reset mid-operation: asynchronous return to the reset state. The first write after release behaves as a write into an empty FIFO.

Test Plan:
- Fill/drain, SHOWAHEAD=1: write 0x0001..0x0010 (16 words) → full_o=1, usedw_o=16, almost_full_o=1 from usedw 12; q_o=0x0001 before any read; 16 reads return 0x0001..0x0010 with no bubbles; empty_o=1 after the last read.
- Normal mode, SHOWAHEAD=0: write 0xA5A5 then assert rdreq_i → q_o=0xA5A5 exactly one cycle after the read edge; q_o holds 0xA5A5 through later idle cycles.
- Full write-through: at usedw=16 (head 0x0001), drive rdreq_i=wrreq_i=1 with data 0x0BEE → head becomes 0x0002, usedw_o stays 16, overflow_o=0. The 16th subsequent read returns 0x0BEE.
- Error flags: wrreq_i alone at full → overflow_o=1, contents unchanged. rdreq_i at empty → underflow_o=1, usedw_o stays 0. Both flags stay high until flush_i, then return to 0.
- Flush precedence: with usedw=5, assert flush_i together with wrreq_i and rdreq_i → next cycle usedw_o=0, empty_o=1, almost_empty_o=1, no flags set.
- Wrap and reset: run 40 mixed writes/reads with random gaps; scoreboard order matches. Pull arst_n_i low mid-stream, between edges → outputs reach the reset state immediately; after release, the first write is read back correctly.

Source files
------------

// File: rtl/fifo_stream.sv
// rtl/fifo_stream.sv - single-clock synchronous FIFO with showahead, write-through, flush and sticky error flags
module fifo_stream #(
    parameter int DWIDTH             = 16,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 1,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              flush_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int              DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_LVL   = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0] AE_LVL   = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] CNT_TWO  = (AWIDTH+1)'(2);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   usedw;
    logic [AWIDTH:0]   usedw_nxt;
    logic [DWIDTH-1:0] q;
    logic [DWIDTH-1:0] q_nxt;
    logic              rd_ok;
    logic              wr_ok;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    assign empty_o = (usedw == '0);
    assign full_o  = (usedw == FULL_CNT);
    assign rd_ok   = rdreq_i & ~empty_o;
    assign wr_ok   = wrreq_i & (~full_o | rd_ok);

    always_comb begin
        usedw_nxt = usedw;
        if (flush_i)
            usedw_nxt = '0;
        else if (wr_ok && !rd_ok)
            usedw_nxt = usedw + CNT_ONE;
        else if (rd_ok && !wr_ok)
            usedw_nxt = usedw - CNT_ONE;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            logic [AWIDTH-1:0] rd_ptr_inc;
            assign rd_ptr_inc = rd_ptr + AWIDTH'(1);
            // q always mirrors the head word; the bypass covers writes that land as the new head
            always_comb begin
                q_nxt = q;
                if (rd_ok) begin
                    if (usedw >= CNT_TWO)
                        q_nxt = mem[rd_ptr_inc];
                    else if (wr_ok)
                        q_nxt = data_i;
                end else if (wr_ok && empty_o) begin
                    q_nxt = data_i;
                end
            end
        end else begin : g_normal
            always_comb begin
                q_nxt = q;
                if (rd_ok)
                    q_nxt = mem[rd_ptr];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush_i)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            q            <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush_i) begin
            // q deliberately holds across a flush
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AWIDTH'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AWIDTH'(1);
            usedw        <= usedw_nxt;
            q            <= q_nxt;
            almost_full  <= (usedw_nxt >= AF_LVL);
            almost_empty <= (usedw_nxt < AE_LVL);
            overflow     <= overflow | (wrreq_i & ~wr_ok);
            underflow    <= underflow | (rdreq_i & ~rd_ok);
        end
    end

    assign q_o            = q;
    assign usedw_o        = usedw;
    assign almost_full_o  = almost_full;
    assign almost_empty_o = almost_empty;
    assign overflow_o     = overflow;
    assign underflow_o    = underflow;

endmodule

// File: tb/tb_fifo_stream.sv
// tb/tb_fifo_stream.sv - directed self-checking bench for fifo_stream (showahead and normal instances)
module tb_fifo_stream;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        flush;
    logic [15:0] data;
    logic        wrreq;
    logic        rdreq;

    logic [15:0] q;
    logic        empty, full, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  usedw;

    logic [15:0] q_n;
    logic        empty_n, full_n, almost_full_n, almost_empty_n, overflow_n, underflow_n;
    logic [4:0]  usedw_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] m[$];
    logic        w, r, rd_ok_m, wr_ok_m, ov_m, un_m;
    logic [15:0] d;

    always #5 clk = ~clk;

    fifo_stream #(.DWIDTH(16), .AWIDTH(4), .SHOWAHEAD(1),
                  .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(2)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush), .data_i(data),
        .wrreq_i(wrreq), .rdreq_i(rdreq), .q_o(q), .empty_o(empty), .full_o(full),
        .usedw_o(usedw), .almost_full_o(almost_full), .almost_empty_o(almost_empty),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    fifo_stream #(.DWIDTH(16), .AWIDTH(4), .SHOWAHEAD(0),
                  .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(2)) dut_n (
        .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush), .data_i(data),
        .wrreq_i(wrreq), .rdreq_i(rdreq), .q_o(q_n), .empty_o(empty_n), .full_o(full_n),
        .usedw_o(usedw_n), .almost_full_o(almost_full_n), .almost_empty_o(almost_empty_n),
        .overflow_o(overflow_n), .underflow_o(underflow_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_usedw"}, usedw, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ae"}, almost_empty, 1);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_ov"}, overflow, 0);
        chk({tag, "_un"}, underflow, 0);
        chk({tag, "_q"}, q, 0);
    endtask

    initial begin
        arst_n = 1'b0; flush = 1'b0; data = '0; wrreq = 1'b0; rdreq = 1'b0;
        #12;
        chk_reset_state("reset");
        chk("reset_q_n", q_n, 0);
        arst_n = 1'b1;
        tick();

        // normal-mode read latency (both instances see the same traffic)
        data = 16'hA5A5; wrreq = 1'b1; tick();
        wrreq = 1'b0;
        chk("norm_q_before_read", q_n, 16'h0000);
        chk("sa_q_after_write", q, 16'hA5A5);
        rdreq = 1'b1; tick();
        rdreq = 1'b0;
        chk("norm_q_after_read", q_n, 16'hA5A5);
        repeat (3) tick();
        chk("norm_q_hold", q_n, 16'hA5A5);
        chk("norm_empty", empty, 1);

        // fill to full
        for (int i = 1; i <= 16; i++) begin
            data = 16'(i); wrreq = 1'b1; tick();
            chk("fill_usedw", usedw, i);
            chk("fill_af", almost_full, (i >= 12) ? 1 : 0);
            chk("fill_ae", almost_empty, (i < 2) ? 1 : 0);
            chk("fill_head", q, 16'h0001);
        end
        wrreq = 1'b0;
        chk("fill_full", full, 1);

        // write-through while full
        data = 16'h0BEE; wrreq = 1'b1; rdreq = 1'b1; tick();
        wrreq = 1'b0; rdreq = 1'b0;
        chk("wt_head", q, 16'h0002);
        chk("wt_usedw", usedw, 16);
        chk("wt_ov", overflow, 0);

        // dropped write at full
        data = 16'hDEAD; wrreq = 1'b1; tick();
        wrreq = 1'b0;
        chk("ov_flag", overflow, 1);
        chk("ov_usedw", usedw, 16);
        chk("ov_head", q, 16'h0002);

        // drain without bubbles
        rdreq = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_q", q, (k == 15) ? 16'h0BEE : 16'(k + 2));
            tick();
            chk("drain_usedw", usedw, 15 - k);
        end
        rdreq = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_q_hold", q, 16'h0BEE);

        // underflow then flush clears both sticky flags
        rdreq = 1'b1; tick();
        rdreq = 1'b0;
        chk("un_flag", underflow, 1);
        chk("un_usedw", usedw, 0);
        tick();
        chk("ov_sticky", overflow, 1);
        chk("un_sticky", underflow, 1);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_ov", overflow, 0);
        chk("flush_un", underflow, 0);

        // flush wins over simultaneous requests
        for (int i = 0; i < 5; i++) begin
            data = 16'h0050 + 16'(i); wrreq = 1'b1; tick();
        end
        wrreq = 1'b0;
        chk("pre_flush_usedw", usedw, 5);
        flush = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 16'h7777; tick();
        flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        chk("fp_usedw", usedw, 0);
        chk("fp_empty", empty, 1);
        chk("fp_ae", almost_empty, 1);
        chk("fp_ov", overflow, 0);
        chk("fp_un", underflow, 0);
        chk("fp_q_hold", q, 16'h0050);

        // mixed traffic against a queue model
        ov_m = 1'b0; un_m = 1'b0;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (!w && !r) w = 1'b1;
            d = 16'($urandom);
            if (m.size() > 0) chk("rand_head", q, m[0]);
            rd_ok_m = r && (m.size() > 0);
            wr_ok_m = w && ((m.size() < 16) || rd_ok_m);
            wrreq = w; rdreq = r; data = d; tick();
            wrreq = 1'b0; rdreq = 1'b0;
            if (rd_ok_m) void'(m.pop_front());
            if (wr_ok_m) m.push_back(d);
            ov_m = ov_m | (w & ~wr_ok_m);
            un_m = un_m | (r & ~rd_ok_m);
            chk("rand_usedw", usedw, m.size());
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("rand_ov", overflow, ov_m);
        chk("rand_un", underflow, un_m);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            data = 16'h0C00 + 16'(i); wrreq = 1'b1; tick();
        end
        wrreq = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        chk_reset_state("arst");
        #3;
        arst_n = 1'b1;
        tick();
        data = 16'h1234; wrreq = 1'b1; tick();
        wrreq = 1'b0;
        chk("post_rst_q", q, 16'h1234);
        chk("post_rst_usedw", usedw, 1);
        rdreq = 1'b1; tick();
        rdreq = 1'b0;
        chk("post_rst_norm_q", q_n, 16'h1234);
        chk("post_rst_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
